// File: rtl/div_radix2_iter.sv
// Iterative restoring radix-2 divider (DIV/DIVU) with a start/ready handshake.
// One quotient bit per cycle; returns {remainder, quotient}.
module div_radix2_iter #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   DBZ_RES = {DW{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DW-1:0]     opdata1_i,
  input  logic [DW-1:0]     opdata2_i,
  input  logic              start_i,
  input  logic              annul_i,
  input  logic              signed_div_i,
  output logic              ready_o,
  output logic [2*DW-1:0]   result_o
);

  localparam int              CW       = $clog2(DW);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DW - 1);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DBZ  = 2'd1,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } state_t;

  function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v, input logic neg);
    if (neg) begin
      cond_neg = -v;
    end else begin
      cond_neg = v;
    end
  endfunction

  state_t            state_r, state_nxt_s;
  logic [DW-1:0]     a_r;          // remaining dividend bits above, quotient bits shifted in below
  logic [DW-1:0]     b_r;
  logic [DW-1:0]     p_r;
  logic [CW-1:0]     cnt_r;
  logic              neg_quo_r, neg_rem_r;
  logic              ready_r;
  logic [2*DW-1:0]   result_r;

  logic              abort_s, start_s, load_res_s, load_dbz_s, ready_nxt_s;
  logic [DW:0]       p_shift_s;
  logic              q_bit_s;
  logic [DW-1:0]     p_nxt_s, a_nxt_s;

  assign abort_s  = flush | annul_i;
  assign ready_o  = ready_r;
  assign result_o = result_r;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state and control decode; abort overrides everything
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    load_res_s  = 1'b0;
    load_dbz_s  = 1'b0;
    ready_nxt_s = 1'b0;
    if (abort_s) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            start_s = 1'b1;
            if (opdata2_i == {DW{1'b0}}) begin
              state_nxt_s = S_DBZ;
            end else begin
              state_nxt_s = S_ON;
            end
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_DBZ: begin
          state_nxt_s = S_END;
          load_dbz_s  = 1'b1;
          ready_nxt_s = 1'b1;
        end
        S_ON: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = S_END;
            load_res_s  = 1'b1;
            ready_nxt_s = 1'b1;
          end else begin
            state_nxt_s = S_ON;
          end
        end
        S_END:   state_nxt_s = S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // one restoring step: p_shift_s is the DW+1-bit partial remainder
  always_comb begin
    p_shift_s = {p_r, a_r[DW-1]};
    q_bit_s   = (p_shift_s >= {1'b0, b_r});
    if (q_bit_s) begin
      p_nxt_s = p_shift_s[DW-1:0] - b_r;
    end else begin
      p_nxt_s = p_shift_s[DW-1:0];
    end
    a_nxt_s = {a_r[DW-2:0], q_bit_s};
  end

  // operand latch, iteration and result/ready registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= {DW{1'b0}};
      b_r       <= {DW{1'b0}};
      p_r       <= {DW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      ready_r   <= 1'b0;
      result_r  <= {(2*DW){1'b0}};
    end else begin
      ready_r <= ready_nxt_s;
      if (start_s) begin
        a_r       <= cond_neg(opdata1_i, signed_div_i & opdata1_i[DW-1]);
        b_r       <= cond_neg(opdata2_i, signed_div_i & opdata2_i[DW-1]);
        p_r       <= {DW{1'b0}};
        cnt_r     <= {CW{1'b0}};
        neg_quo_r <= signed_div_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
        neg_rem_r <= signed_div_i & opdata1_i[DW-1];
      end else if ((state_r == S_ON) && !abort_s) begin
        a_r   <= a_nxt_s;
        p_r   <= p_nxt_s;
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      // sign fix-up folds into the final load so the result is ready on entry to END
      if (load_res_s) begin
        result_r <= {cond_neg(p_nxt_s, neg_rem_r), cond_neg(a_nxt_s, neg_quo_r)};
      end else if (load_dbz_s) begin
        result_r <= {DBZ_RES, DBZ_RES};
      end else begin
        result_r <= result_r;
      end
    end
  end

endmodule
